// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared encodings, state type and width defaults for the pipeline stages
package riscv_pipe_pkg;
  localparam int DW_DEF = 8;
  localparam int AW_DEF = 8;
  localparam int RW_DEF = 3;
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  typedef enum logic {S_IDLE, S_WAIT} mem_state_t;
endpackage

// File: rtl/writeback_pipe_register.sv
// writeback_pipe_register: MEM/WB flops with bubble insertion and a separate read-data load enable
module writeback_pipe_register #(
  parameter int DW = 8,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          bubble,
  input  logic          rd_en,
  input  logic          reg_write_in,
  input  logic [1:0]    result_src_in,
  input  logic [DW-1:0] alu_result_in,
  input  logic [DW-1:0] read_data_in,
  input  logic [DW-1:0] pc_plus4_in,
  input  logic [RW-1:0] rd_in,
  output logic          reg_write,
  output logic [1:0]    result_src,
  output logic [DW-1:0] alu_result,
  output logic [DW-1:0] read_data,
  output logic [DW-1:0] pc_plus4,
  output logic [RW-1:0] rd
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write  <= 1'b0;
      result_src <= 2'b00;
      alu_result <= '0;
      read_data  <= '0;
      pc_plus4   <= '0;
      rd         <= '0;
    end else if (bubble) begin
      reg_write  <= 1'b0;
    end else begin
      reg_write  <= reg_write_in;
      result_src <= result_src_in;
      alu_result <= alu_result_in;
      pc_plus4   <= pc_plus4_in;
      rd         <= rd_in;
      if (rd_en) read_data <= read_data_in;
    end
  end
endmodule

// File: rtl/memory_access_stage.sv
// memory_access_stage: M stage; req/ack data-memory access, front-end stall, MEM/WB register.
// Optional DMEM_TIMEOUT_EN: force-retire a load/store after TIMEOUT_CYCLES cycles without ack.
module memory_access_stage
  import riscv_pipe_pkg::*;
#(
  parameter int DW             = DW_DEF,
  parameter int AW             = AW_DEF,
  parameter int RW             = RW_DEF,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          RegWriteM,
  input  logic          MemWriteM,
  input  logic [1:0]    ResultSrcM,
  input  logic [DW-1:0] ALUResultM,
  input  logic [DW-1:0] WriteDataM,
  input  logic [DW-1:0] pcPlus4M,
  input  logic [RW-1:0] RdM,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic          StallM,
  output logic          RegWriteW,
  output logic [1:0]    ResultSrcW,
  output logic [DW-1:0] ALUResultW,
  output logic [DW-1:0] ReadDataW,
  output logic [DW-1:0] pcPlus4W,
  output logic [RW-1:0] RdW,
  output logic          dmem_err
);
  if (TIMEOUT_CYCLES < 2) $error("TIMEOUT_CYCLES must be at least 2");
  mem_state_t state, nxt;
  logic is_load, memop, tmo;
  assign is_load    = ResultSrcM == RES_MEM;
  assign memop      = MemWriteM | is_load;
  assign dmem_we    = MemWriteM;
  assign dmem_addr  = ALUResultM[AW-1:0];
  assign dmem_wdata = WriteDataM;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end
  always_comb begin
    nxt = state == S_IDLE ? ((memop & ~dmem_ack) ? S_WAIT : S_IDLE)
                          : ((~memop | dmem_ack | tmo) ? S_IDLE : S_WAIT);
  end
  // rst_n gates the request so an access is abandoned the instant reset asserts
  always_comb begin
    dmem_req = rst_n & memop;
    StallM   = rst_n & memop & ~dmem_ack & ~tmo;
  end
`ifdef DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  // cnt = stalled cycles so far, so the TIMEOUT_CYCLES-th cycle without ack retires
  assign tmo = (state == S_WAIT) & memop & ~dmem_ack & (cnt == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      dmem_err <= 1'b0;
    end else begin
      cnt <= StallM ? cnt + 1'b1 : '0;
      if (tmo) dmem_err <= 1'b1;
    end
  end
`else
  assign tmo      = 1'b0;
  assign dmem_err = 1'b0;
`endif
  writeback_pipe_register #(.DW(DW), .RW(RW)) u_wb (
    .clk           (clk),
    .rst_n         (rst_n),
    .bubble        (StallM),
    .rd_en         (is_load),
    .reg_write_in  (RegWriteM),
    .result_src_in (ResultSrcM),
    .alu_result_in (ALUResultM),
    .read_data_in  (tmo ? {DW{1'b1}} : dmem_rdata),
    .pc_plus4_in   (pcPlus4M),
    .rd_in         (RdM),
    .reg_write     (RegWriteW),
    .result_src    (ResultSrcW),
    .alu_result    (ALUResultW),
    .read_data     (ReadDataW),
    .pc_plus4      (pcPlus4W),
    .rd            (RdW)
  );
endmodule
